// File: rtl/hue_wheel_sequencer.sv
// Hue wheel sequencer: walks a full-saturation hue wheel (6 sectors x 256 steps)
// and offers brightness-scaled RGB duty triples to the PWM datapath via valid/ready.
module hue_wheel_sequencer #(
  parameter int CLK_FREQ      = 12000000,
  parameter int STEPS_PER_SEC = 1536
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] brightness,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       duty_valid,
  input  logic       duty_ready,
  output logic [2:0] sector,
  output logic [7:0] ramp,
  output logic       overrun
);

  localparam int DIV = CLK_FREQ / STEPS_PER_SEC;
  localparam int CW  = (DIV > 4) ? $clog2(DIV) : 2;
  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_OFFER   = 2'd3;

  generate
    if (DIV < 4) begin : g_div_check
      $error("hue_wheel_sequencer: CLK_FREQ/STEPS_PER_SEC must be >= 4");
    end
  endgenerate

  logic [CW-1:0] tick_cnt_r;
  logic [1:0]    state_r;
  logic          tick_s;
  logic [23:0]   color_s;

  // Unscaled full-saturation colour {R,G,B} for a sector/ramp position.
  function automatic logic [23:0] wheel_color(input logic [2:0] sec, input logic [7:0] c);
    logic [7:0] n;
    n = 8'd255 - c;
    case (sec)
      3'd0:    wheel_color = {8'd255, c, 8'd0};
      3'd1:    wheel_color = {n, 8'd255, 8'd0};
      3'd2:    wheel_color = {8'd0, 8'd255, c};
      3'd3:    wheel_color = {8'd0, n, 8'd255};
      3'd4:    wheel_color = {c, 8'd0, 8'd255};
      3'd5:    wheel_color = {8'd255, 8'd0, n};
      default: wheel_color = 24'd0;
    endcase
  endfunction

  // (brightness+1) makes 255 an exact pass-through and 0 fully dark.
  function automatic logic [7:0] scale_duty(input logic [7:0] v, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, v} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  // Step tick decode and current unscaled colour.
  always_comb begin
    tick_s  = 1'b0;
    color_s = wheel_color(sector, ramp);
    if (enable && (tick_cnt_r == TICK_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Step-rate divider; held at zero while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= '0;
    end else if (!enable || tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CW'(1);
    end
  end

  // Sequencing FSM, hue position, duty registers and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_INIT;
      sector     <= 3'd0;
      ramp       <= 8'd0;
      duty_r     <= 8'd0;
      duty_g     <= 8'd0;
      duty_b     <= 8'd0;
      duty_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          state_r <= ST_COMPUTE;
        end
        ST_IDLE: begin
          if (tick_s) begin
            ramp <= ramp + 8'd1;
            if (ramp == 8'd255) begin
              sector <= (sector == 3'd5) ? 3'd0 : sector + 3'd1;
            end
            state_r <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          duty_r     <= scale_duty(color_s[23:16], brightness);
          duty_g     <= scale_duty(color_s[15:8], brightness);
          duty_b     <= scale_duty(color_s[7:0], brightness);
          duty_valid <= 1'b1;
          state_r    <= ST_OFFER;
        end
        ST_OFFER: begin
          if (duty_ready) begin
            duty_valid <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        default: begin
          duty_valid <= 1'b0;
          state_r    <= ST_INIT;
        end
      endcase
      // A step arriving while a triple is in flight is dropped, not queued.
      if (tick_s && ((state_r == ST_COMPUTE) || (state_r == ST_OFFER))) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hue_wheel_sequencer.sv
// Self-checking bench for hue_wheel_sequencer: directed scenarios plus randomized
// traffic compared against a transaction-level hue wheel model.
module tb_hue_wheel_sequencer;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'd255;
  logic       duty_ready = 1'b1;
  logic [7:0] duty_r, duty_g, duty_b;
  logic       duty_valid;
  logic [2:0] sector;
  logic [7:0] ramp;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: hue as a single index 0..1535, busy phases as flags.
  int m_hue = 0, m_cnt = 0, m_r = 0, m_g = 0, m_b = 0;
  bit m_init = 1'b1, m_comp = 1'b0, m_offer = 1'b0, m_over = 1'b0;

  hue_wheel_sequencer #(.CLK_FREQ(6144), .STEPS_PER_SEC(1536)) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .sector(sector), .ramp(ramp), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void ref_color(input int hue, input int br, output int r, output int g, output int b);
    int s, c, n, vr, vg, vb;
    s = hue / 256;
    c = hue % 256;
    n = 255 - c;
    vr = 0; vg = 0; vb = 0;
    case (s)
      0: begin vr = 255; vg = c;   vb = 0;   end
      1: begin vr = n;   vg = 255; vb = 0;   end
      2: begin vr = 0;   vg = 255; vb = c;   end
      3: begin vr = 0;   vg = n;   vb = 255; end
      4: begin vr = c;   vg = 0;   vb = 255; end
      default: begin vr = 255; vg = 0; vb = n; end
    endcase
    r = (vr * (br + 1)) / 256;
    g = (vg * (br + 1)) / 256;
    b = (vb * (br + 1)) / 256;
  endfunction

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_hue = 0; m_cnt = 0; m_r = 0; m_g = 0; m_b = 0;
      m_init = 1'b1; m_comp = 1'b0; m_offer = 1'b0; m_over = 1'b0;
    end else begin
      tick = enable && (m_cnt == DIV - 1);
      m_cnt = (enable && !tick) ? m_cnt + 1 : 0;
      if (m_init) begin
        m_init = 1'b0;
        m_comp = 1'b1;
      end else if (m_comp) begin
        ref_color(m_hue, int'(brightness), m_r, m_g, m_b);
        m_comp = 1'b0;
        m_offer = 1'b1;
        if (tick) m_over = 1'b1;
      end else if (m_offer) begin
        if (tick) m_over = 1'b1;
        if (duty_ready) m_offer = 1'b0;
      end else if (tick) begin
        m_hue = (m_hue + 1) % 1536;
        m_comp = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and sample at the following negedge.
  task automatic cyc(input bit r_in, input bit en, input bit rdy, input int br);
    rst = r_in;
    enable = en;
    duty_ready = rdy;
    brightness = 8'(br);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b1, 255);
    checks++;
    if (duty_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", duty_valid); end
    checks++;
    if ({duty_r, duty_g, duty_b} !== 24'h000000) begin
      errors++; $display("FAIL reset_duty got %h want 000000", {duty_r, duty_g, duty_b});
    end
    checks++;
    if ({sector, ramp, overrun} !== 12'h000) begin
      errors++; $display("FAIL reset_pos got s=%0d r=%0d ov=%b want 0/0/0", sector, ramp, overrun);
    end
  endtask

  task automatic test_init_load();
    cyc(1'b1, 1'b0, 1'b1, 255);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 255);
      checks++;
      if (duty_valid !== (k == 2)) begin
        errors++; $display("FAIL init_valid cycle %0d got %b want %b", k, duty_valid, (k == 2));
      end
      if (k == 2) begin
        checks++;
        if ({duty_r, duty_g, duty_b} !== 24'hFF0000) begin
          errors++; $display("FAIL init_duty got %h want ff0000", {duty_r, duty_g, duty_b});
        end
      end
    end
    checks++;
    if ({sector, ramp, overrun} !== 12'h000) begin
      errors++; $display("FAIL init_pos got s=%0d r=%0d ov=%b want 0/0/0", sector, ramp, overrun);
    end
  endtask

  task automatic test_enable();
    int idx;
    logic [23:0] want;
    idx = 0;
    cyc(1'b1, 1'b1, 1'b1, 255);
    for (int k = 1; k <= 14; k++) begin
      bit exp_v;
      cyc(1'b0, 1'b1, 1'b1, 255);
      exp_v = (k == 2) || (k == 5) || (k == 9) || (k == 13);
      checks++;
      if (duty_valid !== exp_v) begin
        errors++; $display("FAIL enable_valid cycle %0d got %b want %b", k, duty_valid, exp_v);
      end
      if (exp_v) begin
        want = {8'hFF, 8'(idx), 8'h00};
        checks++;
        if ({duty_r, duty_g, duty_b} !== want) begin
          errors++; $display("FAIL enable_duty cycle %0d got %h want %h", k, {duty_r, duty_g, duty_b}, want);
        end
        idx++;
      end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL enable_overrun got %b want 0", overrun); end
  endtask

  task automatic test_wrap();
    int offers;
    bit done;
    offers = 0;
    done = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 255);
    for (int k = 0; k < 7000 && !done; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 255);
      if (duty_valid) begin
        if (offers == 256) begin
          checks++;
          if ({sector, ramp, duty_r, duty_g, duty_b} !== {3'd1, 8'd0, 24'hFFFF00}) begin
            errors++; $display("FAIL wrap_256 got s=%0d r=%0d duty=%h want 1/0/ffff00",
                               sector, ramp, {duty_r, duty_g, duty_b});
          end
        end
        if (offers == 1536) begin
          checks++;
          if ({sector, ramp, duty_r, duty_g, duty_b} !== {3'd0, 8'd0, 24'hFF0000}) begin
            errors++; $display("FAIL wrap_1536 got s=%0d r=%0d duty=%h want 0/0/ff0000",
                               sector, ramp, {duty_r, duty_g, duty_b});
          end
          done = 1'b1;
        end
        offers++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL wrap_timeout got %0d offers want 1537", offers); end
  endtask

  task automatic test_brightness();
    int offers, br;
    bit done;
    offers = 0;
    br = 128;
    done = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, br);
    for (int k = 0; k < 2600 && !done; k++) begin
      cyc(1'b0, 1'b1, 1'b1, br);
      if (duty_valid) begin
        if (offers == 512) begin
          checks++;
          if ({sector, ramp, duty_r, duty_g, duty_b} !== {3'd2, 8'd0, 24'h008000}) begin
            errors++; $display("FAIL bright_128 got s=%0d r=%0d duty=%h want 2/0/008000",
                               sector, ramp, {duty_r, duty_g, duty_b});
          end
          br = 0;
        end
        if (offers == 513) begin
          checks++;
          if ({duty_r, duty_g, duty_b} !== 24'h000000) begin
            errors++; $display("FAIL bright_0 got %h want 000000", {duty_r, duty_g, duty_b});
          end
          done = 1'b1;
        end
        offers++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL bright_timeout got %0d offers want 514", offers); end
  endtask

  task automatic test_backpressure();
    bit seen;
    cyc(1'b1, 1'b1, 1'b0, 255);
    cyc(1'b0, 1'b1, 1'b0, 255);
    for (int k = 2; k <= 12; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 255);
      checks++;
      if ({duty_valid, duty_r, duty_g, duty_b, ramp} !== {1'b1, 24'hFF0000, 8'd0}) begin
        errors++; $display("FAIL stall_hold cycle %0d got v=%b duty=%h ramp=%0d want 1/ff0000/0",
                           k, duty_valid, {duty_r, duty_g, duty_b}, ramp);
      end
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL stall_overrun got %b want 1", overrun); end
    cyc(1'b0, 1'b1, 1'b1, 255);
    checks++;
    if (duty_valid !== 1'b0) begin errors++; $display("FAIL stall_release got valid %b want 0", duty_valid); end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 255);
      if (duty_valid) seen = 1'b1;
    end
    checks++;
    if (!seen || {ramp, duty_r, duty_g, duty_b, overrun} !== {8'd1, 24'hFF0100, 1'b1}) begin
      errors++; $display("FAIL stall_next got seen=%b ramp=%0d duty=%h ov=%b want 1/1/ff0100/1",
                         seen, ramp, {duty_r, duty_g, duty_b}, overrun);
    end
  endtask

  task automatic test_reset_mid_handshake();
    cyc(1'b1, 1'b1, 1'b0, 255);
    cyc(1'b0, 1'b1, 1'b0, 255);
    cyc(1'b0, 1'b1, 1'b0, 255);
    checks++;
    if (duty_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got valid %b want 1", duty_valid); end
    cyc(1'b1, 1'b1, 1'b0, 255);
    checks++;
    if ({duty_valid, duty_r, duty_g, duty_b, sector, ramp, overrun} !== 37'd0) begin
      errors++; $display("FAIL midrst_clear got v=%b duty=%h s=%0d r=%0d ov=%b want all 0",
                         duty_valid, {duty_r, duty_g, duty_b}, sector, ramp, overrun);
    end
    cyc(1'b0, 1'b1, 1'b1, 255);
    cyc(1'b0, 1'b1, 1'b1, 255);
    checks++;
    if ({duty_valid, duty_r, duty_g, duty_b} !== {1'b1, 24'hFF0000}) begin
      errors++; $display("FAIL midrst_reload got v=%b duty=%h want 1/ff0000", duty_valid, {duty_r, duty_g, duty_b});
    end
  endtask

  task automatic test_random();
    logic [36:0] got, want;
    int br;
    br = 255;
    cyc(1'b1, 1'b1, 1'b1, br);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) br = int'($urandom_range(0, 255));
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, br);
      got  = {sector, ramp, duty_r, duty_g, duty_b, duty_valid, overrun};
      want = {3'(m_hue / 256), 8'(m_hue % 256), 8'(m_r), 8'(m_g), 8'(m_b), m_offer, m_over};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random cycle %0d got %h want %h", k, got, want);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_init_load();
    test_enable();
    test_wrap();
    test_brightness();
    test_backpressure();
    test_reset_mid_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hue_wheel_sequencer.md
Name: hue_wheel_sequencer

Overview:
- Controller that sequences the RGB PWM datapath through a full-saturation hue wheel.
- Owns a hue position (6 sectors x 256 ramp steps) and advances it at a fixed step rate.
- On each step it computes brightness-scaled 8-bit duty values and offers them to the PWM datapath over a valid/ready handshake.
- Sits between top-level control inputs and the PWM generator's duty-register load port.

Parameters:
- CLK_FREQ, 12000000, input clock frequency in Hz.
- STEPS_PER_SEC, 1536, hue steps per second (default gives one wheel revolution per second).
- DIV (derived), CLK_FREQ/STEPS_PER_SEC, clocks per step. Must be >= 4; elaboration error otherwise.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  1 = hue advances; 0 = hue frozen and tick counter held at 0
- brightness  input  8  global scale; 255 = full, 0 = off
- duty_r  output  8  red duty offered to the PWM datapath
- duty_g  output  8  green duty offered to the PWM datapath
- duty_b  output  8  blue duty offered to the PWM datapath
- duty_valid  output  1  duty_r/g/b are valid and held stable
- duty_ready  input  1  PWM datapath accepts the duty triple
- sector  output  3  current hue sector, 0..5
- ramp  output  8  current position within the sector
- overrun  output  1  sticky; a step tick arrived while a load was pending

Behaviour:
- Reset (rst high at a clk edge):
  - sector=0, ramp=0, duty_r/g/b=0, duty_valid=0, overrun=0.
  - Tick counter = 0; state = INIT.
  - Reset mid-handshake drops duty_valid on the next edge; the pending triple is discarded.
- Tick counter:
  - Counts 0..DIV-1 while enable=1. tick=1 on the cycle it equals DIV-1, after which it returns to 0.
  - While enable=0 the counter is forced to 0 and tick=0.
- FSM states are INIT, IDLE, COMPUTE, OFFER.
  - INIT: go to COMPUTE next cycle with no hue advance. This is the initial load of hue 0 (red), independent of enable.
  - IDLE, tick=1: advance hue this cycle, then go to COMPUTE.
  - IDLE, no tick: stay in IDLE.
  - COMPUTE (single cycle): register duty_r/g/b from the current sector/ramp and the brightness sampled this cycle. Set duty_valid=1; go to OFFER.
  - OFFER: hold duty_r/g/b and duty_valid stable. When duty_valid&&duty_ready at an edge, clear duty_valid on that edge and go to IDLE.
- Hue advance:
  - ramp <= ramp+1.
  - On ramp 255->0, sector <= sector+1; sector wraps 5->0.
- Latency and throughput:
  - Tick on cycle T gives duty_valid high from cycle T+2.
  - With duty_ready held high, duty_valid is high for exactly 1 cycle.
- Overrun:
  - A tick in COMPUTE or OFFER sets overrun=1 (sticky until rst).
  - The hue is not advanced for that tick; the dropped step is not queued.
- Sector colour mapping (c = ramp, n = 255-ramp), pre-scale (R,G,B):
  - s0 (255,c,0)
  - s1 (n,255,0)
  - s2 (0,255,c)
  - s3 (0,n,255)
  - s4 (c,0,255)
  - s5 (255,0,n)
- Scaling:
  - duty = (v * (brightness+1)) >> 8, using a 16-bit unsigned product.
  - brightness=255 gives duty=v exactly; brightness=0 gives duty = v>>8 = 0.
- brightness changes affect only the next COMPUTE; a triple already offered is never altered.
- enable deasserted during COMPUTE/OFFER: the handshake completes normally, then the FSM stays in IDLE.

Test Plan (DIV=4, i.e. CLK_FREQ=6144, STEPS_PER_SEC=1536):
- Reset, brightness=255, enable=0, ready=1 -> one load of (255,0,0) two cycles after reset release; no further valid; sector=0, ramp=0, overrun=0.
- enable=1, ready=1 -> valid pulses every 4 cycles; successive triples (255,1,0), (255,2,0)...; the 2nd valid follows its tick by exactly 2 cycles.
- Run 256 steps from reset -> sector=1, ramp=0, duty (255,255,0). After 1536 steps -> sector=0, ramp=0, duty (255,0,0) (wrap).
- brightness=128 at the hue sector=2/ramp=0 -> duty (0,128,0). brightness=0 -> (0,0,0).
- ready=0 held for 10 cycles during OFFER -> duty and valid stable throughout; overrun=1; ramp advances by exactly 1 total; one transfer when ready returns to 1.
- Assert rst while duty_valid=1 and ready=0 -> next edge: duty_valid=0, duties 0, sector/ramp 0, overrun 0. Initial red load repeats after release.
